// File: rtl/hash_ctrl_pkg.sv
// hash_ctrl shared definitions: CSR offsets, STATUS bit positions, FSM states.
package hash_ctrl_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_LEN    = 5'h08;
    localparam logic [4:0] OFF_RET    = 5'h0C;
    localparam logic [4:0] OFF_CYCLES = 5'h10;
    localparam logic [4:0] OFF_RUNS   = 5'h14;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_OVERRUN = 3;

    localparam logic [31:0] WIN_SIZE = 32'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/hash_ctrl.sv
// CSR front-end and start/done sequencer for an ap_ctrl style hash core.
// Define HASH_CTRL_PERF_EN to implement the CYCLES and RUNS counters.
module hash_ctrl
    import hash_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00000000,
    parameter int unsigned TIMEOUT   = 1048576
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        ap_start_o,
    output logic [31:0] len_o,
    input  logic        ap_done_i,
    input  logic        ap_ready_i,
    input  logic        ap_idle_i,
    input  logic [31:0] ap_return_i,
    output logic        irq_o
);

    localparam logic [31:0] TMO = 32'(TIMEOUT);

    state_t      r_state;
    logic [1:0]  r_sync;
    logic [31:0] r_len;
    logic [31:0] r_len_o;
    logic [31:0] r_ret;
    logic [31:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_tmo;
    logic        r_ovr;
    logic        r_resp;

    logic [31:0] w_off;
    logic [4:0]  w_reg;
    logic [31:0] w_cnt_nx;
    logic [31:0] w_rdata;
    logic [31:0] w_cycles;
    logic [31:0] w_runs;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic        w_start;
    logic        w_clear;
    logic        w_len_wr;
    logic        w_busy;
    logic        w_fin;
    logic        w_tmo_hit;
    logic        w_abort;
    logic        w_unused;

    // Wrapping subtract: addresses below the base land far outside the window.
    assign w_off    = bus_addr_bi - BASE_ADDR;
    assign w_reg    = w_off[4:0];
    assign w_acc    = bus_req_i && (w_off < WIN_SIZE);
    assign w_wr     = w_acc && bus_we_i;
    assign w_rd     = w_acc && !bus_we_i;
    assign w_start  = w_wr && (w_reg == OFF_CTRL) && bus_wdata_bi[CTRL_START];
    assign w_clear  = w_wr && (w_reg == OFF_CTRL) && bus_wdata_bi[CTRL_CLEAR];
    assign w_len_wr = w_wr && (w_reg == OFF_LEN);

    assign w_busy    = (r_state == S_START) || (r_state == S_WAIT);
    assign w_cnt_nx  = (&r_cnt) ? r_cnt : r_cnt + 32'd1;
    assign w_tmo_hit = w_cnt_nx >= TMO;
    assign w_fin     = ((r_state == S_START) && ap_ready_i && ap_done_i)
                    || ((r_state == S_WAIT) && ap_done_i);
    assign w_abort   = w_busy && !w_fin && w_tmo_hit;
    assign w_unused  = ap_idle_i;

    assign bus_ack_o    = w_acc;
    assign bus_resp_o   = r_resp;
    assign bus_rdata_bo = r_rdata;
    assign ap_start_o   = (r_state == S_START);
    assign len_o        = r_len_o;
    assign irq_o        = r_done;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= S_IDLE;
            r_len_o <= '0;
            r_ret   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start && r_sync[1]) begin
                        r_state <= S_START;
                        r_len_o <= r_len;
                        r_cnt   <= '0;
                    end
                end
                S_START, S_WAIT: begin
                    r_cnt <= w_cnt_nx;
                    if (w_fin) begin
                        r_state <= S_DONE;
                        r_ret   <= ap_return_i;
                    end else if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                    end else if (r_state == S_START && ap_ready_i) begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Clear is applied first so a same-cycle set still lands.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_done <= 1'b0;
            r_tmo  <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_clear) begin
                r_done <= 1'b0;
                r_tmo  <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (r_state == S_DONE) r_done <= 1'b1;
            if (w_abort) r_tmo <= 1'b1;
            if (w_start && w_busy) r_ovr <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_len <= '0;
        end else if (w_len_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be_bi[b]) r_len[8*b +: 8] <= bus_wdata_bi[8*b +: 8];
            end
        end
    end

`ifdef HASH_CTRL_PERF_EN
    logic [31:0] r_cycles;
    logic [31:0] r_runs;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cycles <= '0;
            r_runs   <= '0;
        end else begin
            if (w_fin || w_abort) r_cycles <= w_cnt_nx;
            if (r_state == S_DONE) r_runs <= r_runs + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
    assign w_runs   = r_runs;
`else
    assign w_cycles = '0;
    assign w_runs   = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            OFF_STATUS: begin
                w_rdata[STAT_BUSY]    = w_busy;
                w_rdata[STAT_DONE]    = r_done;
                w_rdata[STAT_TIMEOUT] = r_tmo;
                w_rdata[STAT_OVERRUN] = r_ovr;
            end
            OFF_LEN:    w_rdata = r_len;
            OFF_RET:    w_rdata = r_ret;
            OFF_CYCLES: w_rdata = w_cycles;
            OFF_RUNS:   w_rdata = w_runs;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp  <= w_rd;
            r_rdata <= w_rd ? w_rdata : 32'h0;
        end
    end

endmodule

// File: doc/hash_ctrl.md
HASH_CTRL -- requirements
Module: hash_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000, byte base of the 0x20-byte CSR window.
REQ-002 SHALL have parameter TIMEOUT, default 1048576, maximum cycles in WAIT before abort.
REQ-003 SHALL have port clk_i, input, 1, sole clock.
REQ-004 SHALL have port arst_n_i, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have bus slave inputs: bus_req_i 1, bus_we_i 1, bus_addr_bi 32, bus_be_bi 4, bus_wdata_bi 32.
REQ-006 SHALL have bus slave outputs: bus_ack_o 1, bus_resp_o 1, bus_rdata_bo 32.
REQ-007 SHALL have core-side outputs: ap_start_o 1 (start strobe to the hash core) and len_o 32 (frame length to the core).
REQ-008 SHALL have core-side inputs: ap_done_i 1, ap_ready_i 1, ap_idle_i 1, ap_return_i 32.
REQ-009 SHALL have port irq_o, output, 1, level interrupt while STATUS.done=1.

Function
REQ-010 SHALL decode offsets as follows:
- 0x00 CTRL, write-only: bit0 start, bit1 clear.
- 0x04 STATUS, read-only: bit0 busy, bit1 done, bit2 timeout, bit3 overrun.
- 0x08 LEN, read/write.
- 0x0C RET, read-only.
- 0x10 CYCLES, read-only.
- 0x14 RUNS, read-only.
REQ-011 SHALL assert bus_ack_o = bus_req_i combinationally when the address is inside the window, and 0 otherwise.
REQ-012 SHALL assert bus_resp_o for exactly one cycle, 1 cycle after an accepted read; bus_rdata_bo SHALL be 0 whenever bus_resp_o=0.
REQ-013 SHALL answer reads of unmapped in-window offsets with resp=1 and rdata=0; accepted writes produce no resp.
REQ-014 SHALL apply bus_be_bi per byte on LEN writes; other writes ignore bus_be_bi.
REQ-015 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-016 IDLE->START SHALL occur on a CTRL.start write, which latches LEN into len_o.
REQ-017 ap_start_o SHALL be 1 only in START.
REQ-018 START->WAIT SHALL occur on ap_ready_i; START->DONE SHALL occur directly if ap_done_i is also 1.
REQ-019 WAIT->DONE SHALL occur on ap_done_i, capturing ap_return_i into RET in the same cycle.
REQ-020 DONE SHALL set STATUS.done, increment RUNS, and return to IDLE the next cycle.
REQ-021 STATUS.busy SHALL be 1 in START and WAIT.
REQ-022 len_o SHALL stay stable from START until DONE; LEN writes while busy update the register only.
REQ-023 A CTRL.start write while busy SHALL be ignored and set STATUS.overrun.
REQ-024 The cycle counter SHALL count cycles spent in START+WAIT, saturate at 32'hFFFFFFFF, and be copied into CYCLES on DONE or on timeout.
REQ-025 If the counter reaches TIMEOUT in START or WAIT, the FSM SHALL go to IDLE, set STATUS.timeout, and leave RET unchanged.
REQ-026 CTRL.clear SHALL zero done, timeout and overrun; if written together with start, clear SHALL apply first, then start.
REQ-027 A STATUS read in the same cycle as a flag set SHALL return the pre-update value.

Reset
REQ-028 On arst_n_i=0, all outputs and registers SHALL reset asynchronously: FSM=IDLE; LEN, RET, CYCLES, RUNS, STATUS = 0; ap_start_o=0; bus_resp_o=0; irq_o=0.
REQ-029 Reset asserted mid-run SHALL abort to IDLE with no done, RET or RUNS update; reset release SHALL be synchronized internally before the FSM leaves IDLE.

Configuration
REQ-030 With macro HASH_CTRL_PERF_EN defined, the CYCLES and RUNS registers SHALL be implemented.
REQ-031 Without HASH_CTRL_PERF_EN, CYCLES and RUNS SHALL read 0, their flops SHALL be removed, and timeout detection SHALL remain intact.

Structure
REQ-032 Register offsets, STATUS bit indices and the FSM state enum SHALL live in shared package hash_ctrl_pkg.
REQ-033 The design SHALL be a single module with no sub-modules.

Verification
REQ-034 Write LEN=16, start; core raises ap_ready 2 cycles later and ap_done with return 32'hCAFE0001 5 cycles later -> RET=32'hCAFE0001, STATUS=0x2, RUNS=1, CYCLES=7, irq_o=1.
REQ-035 Core ap_ready and ap_done high in the same cycle as START -> FSM goes START->DONE, CYCLES=1.
REQ-036 TIMEOUT=100, core never completes -> STATUS=0x4 at cycle 100, RET unchanged, ap_start_o=0.
REQ-037 Start write during WAIT -> STATUS.overrun=1, len_o unchanged, single DONE.
REQ-038 arst_n_i pulsed low during WAIT -> all registers read 0; a subsequent start completes normally with RUNS=1.
REQ-039 Read offset 0x1C -> resp=1 one cycle later, rdata=0; read at BASE_ADDR+0x20 -> ack=0, no resp.
